// File: rtl/cavlc_bit_packer.sv
// cavlc_bit_packer: packs right-aligned CAVLC codewords (0..16 bits) MSB-first
// into 32-bit bitstream words with a valid/ready output handshake. A flush
// closes the block: optional RBSP stop bit, zero padding, last-word tag and a
// done pulse.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// S_RUN        | accept codewords, emit full words, latch a flush request
// S_FLUSH_STOP | drain until there is room, then append the stop bit
// S_FLUSH_DRAIN| emit remaining full words; an exactly-full word is the last
// S_FLUSH_PAD  | emit the partial word, zero padded, as the last word
// S_FLUSH_DONE | pulse done, clear the bit counter and the flush request
module cavlc_bit_packer #(
  parameter int WORD_W       = 32,
  parameter int MAX_CODE_LEN = 16,
  parameter int STOP_BIT     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    code_valid_i,
  output logic                    code_ready_o,
  input  logic [MAX_CODE_LEN-1:0] code_bits_i,
  input  logic [4:0]              code_len_i,
  input  logic                    flush_i,
  output logic                    word_valid_o,
  input  logic                    word_ready_i,
  output logic [WORD_W-1:0]       word_data_o,
  output logic                    word_last_o,
  output logic                    done_o,
  output logic [15:0]             total_bits_o
);

  localparam int         BUF_W     = WORD_W + MAX_CODE_LEN;
  localparam logic [5:0] WORD_FILL = 6'(WORD_W);
  localparam logic [5:0] FULL_FILL = 6'(BUF_W);
  localparam logic [4:0] MAX_LEN   = 5'(MAX_CODE_LEN);

  typedef enum logic [2:0] {
    S_RUN,
    S_FLUSH_STOP,
    S_FLUSH_DRAIN,
    S_FLUSH_PAD,
    S_FLUSH_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [5:0]       fill_q, fill_d;
  logic             pend_q, pend_d;
  logic [15:0]      total_q, total_d;

  logic                    hs;
  logic                    accept;
  logic [4:0]              len_eff;
  logic [MAX_CODE_LEN:0]   len_mask;
  logic [MAX_CODE_LEN-1:0] masked;
  logic [BUF_W-1:0]        buf_hs;
  logic [5:0]              fill_hs;
  logic [5:0]              code_shift;
  logic [BUF_W-1:0]        code_placed;
  logic [BUF_W-1:0]        stop_placed;
  logic [16:0]             total_sum;

  assign word_data_o  = buf_q[BUF_W-1 -: WORD_W];
  assign total_bits_o = total_q;

  // Handshake-qualifying outputs, decoded from state and fill level.
  // code_ready is also gated by the reset input so it stays low while reset is held.
  always_comb begin
    word_valid_o = 1'b0;
    word_last_o  = 1'b0;
    done_o       = 1'b0;
    code_ready_o = 1'b0;
    unique case (state_q)
      S_RUN: begin
        word_valid_o = (fill_q >= WORD_FILL);
        code_ready_o = rst && (fill_q <= WORD_FILL) && !pend_q;
      end
      S_FLUSH_STOP: word_valid_o = (fill_q >= WORD_FILL);
      S_FLUSH_DRAIN: begin
        word_valid_o = (fill_q >= WORD_FILL);
        word_last_o  = (fill_q == WORD_FILL);
      end
      S_FLUSH_PAD: begin
        word_valid_o = 1'b1;
        word_last_o  = 1'b1;
      end
      S_FLUSH_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  // Codeword conditioning and buffer positions after any same-cycle word handshake.
  always_comb begin
    hs          = word_valid_o && word_ready_i;
    accept      = code_valid_i && code_ready_o;
    len_eff     = (code_len_i > MAX_LEN) ? MAX_LEN : code_len_i;
    len_mask    = ((MAX_CODE_LEN+1)'(1) << len_eff) - (MAX_CODE_LEN+1)'(1);
    masked      = code_bits_i & len_mask[MAX_CODE_LEN-1:0];
    buf_hs      = hs ? (buf_q << WORD_W) : buf_q;
    fill_hs     = hs ? (fill_q - WORD_FILL) : fill_q;
    code_shift  = FULL_FILL - fill_hs - {1'b0, len_eff};
    code_placed = {{WORD_W{1'b0}}, masked} << code_shift;
    stop_placed = BUF_W'(1) << (FULL_FILL - 6'd1 - fill_hs);
    total_sum   = {1'b0, total_q} + 17'(len_eff);
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_hs;
    fill_d  = fill_hs;
    pend_d  = pend_q;
    total_d = total_q;
    unique case (state_q)
      S_RUN: begin
        if (accept) begin
          buf_d   = buf_hs | code_placed;
          fill_d  = fill_hs + {1'b0, len_eff};
          total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
        end
        if (flush_i) pend_d = 1'b1;
        if (pend_q) state_d = S_FLUSH_STOP;
      end
      S_FLUSH_STOP: begin
        if (STOP_BIT != 0) begin
          if (fill_hs < FULL_FILL) begin
            buf_d   = buf_hs | stop_placed;
            fill_d  = fill_hs + 6'd1;
            state_d = S_FLUSH_DRAIN;
          end
        end else begin
          state_d = S_FLUSH_DRAIN;
        end
      end
      S_FLUSH_DRAIN: begin
        if (hs) begin
          if (fill_q == WORD_FILL) state_d = S_FLUSH_DONE;
        end else if (fill_q == 6'd0) begin
          state_d = S_FLUSH_DONE;
        end else if (fill_q < WORD_FILL) begin
          state_d = S_FLUSH_PAD;
        end
      end
      S_FLUSH_PAD: begin
        fill_d = fill_q;
        buf_d  = buf_q;
        if (hs) begin
          buf_d   = '0;
          fill_d  = 6'd0;
          state_d = S_FLUSH_DONE;
        end
      end
      S_FLUSH_DONE: begin
        total_d = 16'd0;
        pend_d  = 1'b0;
        state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // State and datapath registers; reset discards any buffered bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      buf_q   <= '0;
      fill_q  <= 6'd0;
      pend_q  <= 1'b0;
      total_q <= 16'd0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      pend_q  <= pend_d;
      total_q <= total_d;
    end
  end

endmodule

// File: tb/tb_cavlc_bit_packer.sv
// Testbench for cavlc_bit_packer: directed scenarios plus randomized traffic
// checked against a bit-queue reference model.
module tb_cavlc_bit_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        code_valid_i = 1'b0;
  logic        code_ready_o;
  logic [15:0] code_bits_i = '0;
  logic [4:0]  code_len_i = '0;
  logic        flush_i = 1'b0;
  logic        word_valid_o;
  logic        word_ready_i = 1'b0;
  logic [31:0] word_data_o;
  logic        word_last_o;
  logic        done_o;
  logic [15:0] total_bits_o;

  cavlc_bit_packer dut (
    .clk(clk), .rst(rst),
    .code_valid_i(code_valid_i), .code_ready_o(code_ready_o),
    .code_bits_i(code_bits_i), .code_len_i(code_len_i),
    .flush_i(flush_i),
    .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .word_data_o(word_data_o), .word_last_o(word_last_o),
    .done_o(done_o), .total_bits_o(total_bits_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  // reference model: stream of bits, cut into 32-bit words
  bit          mbits[$];
  logic [31:0] exp_data[$];
  bit          exp_last[$];
  logic [31:0] obs_data[$];
  bit          obs_last[$];
  int          model_total = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          last_hs_cyc = -1;
  int          mlen;

  function automatic void model_pop_full();
    logic [31:0] w;
    while (mbits.size() >= 32) begin
      w = '0;
      for (int i = 0; i < 32; i++) w = {w[30:0], 1'(mbits.pop_front())};
      exp_data.push_back(w);
      exp_last.push_back(1'b0);
    end
  endfunction

  function automatic void model_flush();
    mbits.push_back(1'b1);
    while (mbits.size() % 32 != 0) mbits.push_back(1'b0);
    model_pop_full();
    exp_last[exp_last.size()-1] = 1'b1;
  endfunction

  function automatic void clear_all();
    obs_data.delete(); obs_last.delete();
    exp_data.delete(); exp_last.delete();
  endfunction

  // monitor: records handshakes that take effect at the coming rising edge
  always @(negedge clk) begin
    if (!rst) begin
      mbits.delete();
      model_total = 0;
    end else begin
      if (word_valid_o && word_ready_i) begin
        obs_data.push_back(word_data_o);
        obs_last.push_back(word_last_o);
        last_hs_cyc = cyc;
      end
      if (code_valid_i && code_ready_o) begin
        mlen = (code_len_i > 5'd16) ? 16 : int'(code_len_i);
        for (int i = mlen - 1; i >= 0; i--) mbits.push_back(code_bits_i[i]);
        model_pop_full();
        model_total = (model_total + mlen > 65535) ? 65535 : model_total + mlen;
      end
      if (flush_i) model_flush();
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        model_total = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] c, input logic [4:0] l, input bit f, output bit ok);
    code_bits_i = c; code_len_i = l; code_valid_i = 1'b1; flush_i = f; ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = code_ready_o;
      @(posedge clk); #1;
      flush_i = 1'b0;
    end
    code_valid_i = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL send_accept: code %h not accepted within 100 cycles, required accept", c); end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (done_o) ok = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_flush(output bit ok);
    flush_i = 1'b1;
    tick(1);
    flush_i = 1'b0;
    wait_done(ok);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(2);
    n_checks++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_word_valid: got %b want 0", word_valid_o); end
    n_checks++; if (word_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_word_last: got %b want 0", word_last_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
    n_checks++; if (code_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_code_ready: got %b want 0", code_ready_o); end
    n_checks++; if (total_bits_o !== 16'd0) begin n_fail++; $display("FAIL reset_total: got %0d want 0", total_bits_o); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (code_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", code_ready_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_word();
    bit ok;
    clear_all();
    word_ready_i = 1'b1;
    send(16'h00AB, 5'd8, 0, ok);
    send(16'h00CD, 5'd8, 0, ok);
    send(16'h00EF, 5'd8, 0, ok);
    send(16'h0012, 5'd8, 0, ok);
    tick(3);
    n_checks++; if (obs_data.size() != 1 || obs_data[0] !== 32'hABCDEF12 || obs_last[0] !== 1'b0) begin
      n_fail++; $display("FAIL basic_word: got %0d words first %h last %b, want 1 word abcdef12 last 0",
                         obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 32'h0, (obs_last.size() > 0) ? obs_last[0] : 1'b0); end
    n_checks++; if (total_bits_o !== 16'd32) begin n_fail++; $display("FAIL basic_total: got %0d want 32", total_bits_o); end
    do_flush(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_flush_done: done not seen, required within 200 cycles"); end
    n_checks++; if (obs_data.size() != 2 || obs_data[1] !== 32'h80000000 || obs_last[1] !== 1'b1) begin
      n_fail++; $display("FAIL basic_stop_word: got %0d words, want 2 with final 80000000 last", obs_data.size()); end
  endtask

  task automatic test_flush();
    bit ok;
    clear_all();
    word_ready_i = 1'b1;
    send(16'hFFFF, 5'd16, 0, ok);
    send(16'h0000, 5'd16, 0, ok);
    send(16'h0005, 5'd3, 0, ok);
    tick(1);
    n_checks++; if (total_bits_o !== 16'd35) begin n_fail++; $display("FAIL flush_total_before: got %0d want 35", total_bits_o); end
    do_flush(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL flush_done_seen: done not seen, required within 200 cycles"); end
    n_checks++; if (obs_data.size() < 1 || obs_data[0] !== 32'hFFFF0000 || obs_last[0] !== 1'b0) begin
      n_fail++; $display("FAIL flush_word1: got %h, want ffff0000 not last", (obs_data.size() > 0) ? obs_data[0] : 32'h0); end
    n_checks++; if (obs_data.size() != 2 || obs_data[1] !== 32'hB0000000 || obs_last[1] !== 1'b1) begin
      n_fail++; $display("FAIL flush_final_word: got %0d words last %h, want b0000000 last", obs_data.size(),
                         (obs_data.size() > 1) ? obs_data[1] : 32'h0); end
    n_checks++; if (done_cyc != last_hs_cyc + 1) begin
      n_fail++; $display("FAIL flush_done_timing: done at cycle %0d, want %0d", done_cyc, last_hs_cyc + 1); end
    @(negedge clk);
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL flush_done_width: got %b want 0 after one cycle", done_o); end
    n_checks++; if (total_bits_o !== 16'd0) begin n_fail++; $display("FAIL flush_total_after: got %0d want 0", total_bits_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit ok, stable;
    logic [15:0] r1, r2, r3;
    logic [31:0] held;
    clear_all();
    r1 = 16'($urandom); r2 = 16'($urandom); r3 = 16'($urandom);
    word_ready_i = 1'b0;
    send(r1, 5'd16, 0, ok);
    send(r2, 5'd16, 0, ok);
    send(r3, 5'd16, 0, ok);
    stable = 1'b1;
    @(negedge clk);
    held = word_data_o;
    for (int i = 0; i < 4; i++) begin
      if (word_data_o !== held || word_valid_o !== 1'b1 || code_ready_o !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    n_checks++; if (!stable) begin n_fail++; $display("FAIL bp_hold: word or ready changed during stall, want valid=1 ready=0 data %h", held); end
    n_checks++; if (held !== {r1, r2}) begin n_fail++; $display("FAIL bp_data: got %h want %h", held, {r1, r2}); end
    @(posedge clk); #1;
    word_ready_i = 1'b1;
    @(negedge clk);
    n_checks++; if (code_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_during_drain: got %b want 0", code_ready_o); end
    @(negedge clk);
    n_checks++; if (code_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_reassert: got %b want 1", code_ready_o); end
    @(posedge clk); #1;
    do_flush(ok);
    n_checks++; if (obs_data.size() != 2 || obs_data[1] !== {r3, 16'h8000} || obs_last[1] !== 1'b1) begin
      n_fail++; $display("FAIL bp_final: got %0d words, want 2 with final %h last", obs_data.size(), {r3, 16'h8000}); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    logic [15:0] a, b, c;
    clear_all();
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
    word_ready_i = 1'b0;
    send(a, 5'd16, 0, ok);
    send(b, 5'd16, 0, ok);
    tick(1);
    word_ready_i = 1'b1;
    send(16'h8001, 5'd16, 0, ok);
    @(negedge clk);
    n_checks++; if (word_valid_o !== 1'b0 || code_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL sim_fill16: valid %b ready %b, want valid 0 ready 1", word_valid_o, code_ready_o); end
    @(posedge clk); #1;
    send(c, 5'd16, 0, ok);
    tick(2);
    n_checks++; if (obs_data.size() != 2 || obs_data[0] !== {a, b} || obs_data[1] !== {16'h8001, c}) begin
      n_fail++; $display("FAIL sim_words: got %0d words, want %h then %h", obs_data.size(), {a, b}, {16'h8001, c}); end
    do_flush(ok);
    n_checks++; if (obs_data.size() != 3 || obs_data[2] !== 32'h80000000) begin
      n_fail++; $display("FAIL sim_flush: got %0d words, want 3 ending 80000000", obs_data.size()); end
  endtask

  task automatic test_masking();
    bit ok;
    clear_all();
    word_ready_i = 1'b1;
    send(16'hFFFF, 5'd4, 0, ok);
    send(16'h1234, 5'd20, 0, ok);
    send(16'hFABC, 5'd12, 0, ok);
    tick(2);
    n_checks++; if (obs_data.size() != 1 || obs_data[0] !== 32'hF1234ABC) begin
      n_fail++; $display("FAIL mask_word: got %h want f1234abc", (obs_data.size() > 0) ? obs_data[0] : 32'h0); end
    n_checks++; if (total_bits_o !== 16'd32) begin n_fail++; $display("FAIL mask_total: got %0d want 32", total_bits_o); end
    do_flush(ok);
  endtask

  task automatic test_flush_with_code();
    bit ok;
    logic [15:0] x;
    clear_all();
    x = 16'($urandom);
    word_ready_i = 1'b1;
    send(x, 5'd10, 1, ok);
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL fwc_done: done not seen, required within 200 cycles"); end
    n_checks++; if (obs_data.size() != 1 || obs_data[0] !== {x[9:0], 1'b1, 21'b0} || obs_last[0] !== 1'b1) begin
      n_fail++; $display("FAIL fwc_word: got %0d words, want 1 word %h last", obs_data.size(), {x[9:0], 1'b1, 21'b0}); end
  endtask

  task automatic test_reset_mid_pad();
    bit ok, found;
    logic [15:0] a, b;
    clear_all();
    a = 16'($urandom); b = 16'($urandom);
    word_ready_i = 1'b0;
    send(a, 5'd16, 0, ok);
    send(b, 5'd4, 0, ok);
    flush_i = 1'b1; tick(1); flush_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (word_valid_o && word_last_o) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rpad_reach: padded last word not seen, required within 50 cycles"); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (word_valid_o !== 1'b0 || done_o !== 1'b0 || code_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL rpad_outputs: valid %b done %b ready %b, want all 0", word_valid_o, done_o, code_ready_o); end
    clear_all();
    tick(2);
    rst = 1'b1;
    word_ready_i = 1'b1;
    @(negedge clk);
    n_checks++; if (code_ready_o !== 1'b1 || word_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rpad_release: ready %b valid %b, want ready 1 valid 0", code_ready_o, word_valid_o); end
    @(posedge clk); #1;
    a = 16'($urandom); b = 16'($urandom);
    send(a, 5'd16, 0, ok);
    send(b, 5'd16, 0, ok);
    tick(2);
    n_checks++; if (obs_data.size() != 1 || obs_data[0] !== {a, b} || obs_last[0] !== 1'b0) begin
      n_fail++; $display("FAIL rpad_restart: got %0d words, want 1 word %h not last", obs_data.size(), {a, b}); end
    do_flush(ok);
  endtask

  task automatic test_saturation();
    bit ok;
    int bad;
    clear_all();
    word_ready_i = 1'b1;
    for (int i = 0; i < 4095; i++) send(16'($urandom), 5'd16, 0, ok);
    tick(1);
    n_checks++; if (total_bits_o !== 16'd65520) begin n_fail++; $display("FAIL sat_before: got %0d want 65520", total_bits_o); end
    send(16'($urandom), 5'd16, 0, ok);
    send(16'($urandom), 5'd16, 0, ok);
    tick(1);
    n_checks++; if (total_bits_o !== 16'hFFFF) begin n_fail++; $display("FAIL sat_clamp: got %0d want 65535", total_bits_o); end
    do_flush(ok);
    n_checks++; if (obs_data.size() != exp_data.size()) begin
      n_fail++; $display("FAIL sat_count: got %0d words want %0d", obs_data.size(), exp_data.size()); end
    bad = 0;
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++)
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL sat_stream: %0d words differ from model, want 0", bad); end
  endtask

  task automatic test_random();
    bit ok, stop_r;
    int nsend;
    for (int blk = 0; blk < 5; blk++) begin
      clear_all();
      nsend = $urandom_range(5, 40);
      stop_r = 1'b0;
      fork
        begin
          for (int n = 0; n < nsend; n++) send(16'($urandom), 5'($urandom_range(0, 31)), 0, ok);
          stop_r = 1'b1;
        end
        begin
          while (!stop_r) begin
            word_ready_i = 1'($urandom_range(0, 1));
            tick(1);
          end
        end
      join
      word_ready_i = 1'b1;
      tick(1);
      n_checks++; if (total_bits_o !== 16'(model_total)) begin
        n_fail++; $display("FAIL rand_total blk %0d: got %0d want %0d", blk, total_bits_o, model_total); end
      do_flush(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_done blk %0d: done not seen, required within 200 cycles", blk); end
      n_checks++; if (obs_data.size() != exp_data.size()) begin
        n_fail++; $display("FAIL rand_count blk %0d: got %0d words want %0d", blk, obs_data.size(), exp_data.size()); end
      for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
        n_checks++;
        if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
          n_fail++; $display("FAIL rand_word blk %0d idx %0d: got %h/%b want %h/%b", blk, i,
                             obs_data[i], obs_last[i], exp_data[i], exp_last[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_flush();
    test_backpressure();
    test_simultaneous();
    test_masking();
    test_flush_with_code();
    test_reset_mid_pad();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
